// File: rtl/bcd_scan_display.sv
// bcd_scan_display: multiplexed multi-digit 7-segment driver.
// Holds a shadow copy of a packed BCD word and scans it one digit per
// prescaler slot. It adds leading-zero blanking, per-digit decimal points
// and a whole-display blink. seg/dp/an are registered together, so there is
// no skew between the segment lines and the digit enables.
module bcd_scan_display #(
    parameter int unsigned DIGITS         = 4,
    parameter int unsigned PRESCALE       = 50000,
    parameter int unsigned BLINK_SCANS    = 64,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load,
    input  logic                  blank_lz,
    input  logic                  blink_en,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  slot_tick
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned BW = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;

    localparam logic [PW-1:0]     PRE_LAST   = PW'(PRESCALE - 1);
    localparam logic [IW-1:0]     IDX_LAST   = IW'(DIGITS - 1);
    localparam logic [BW-1:0]     BLINK_LAST = BW'(BLINK_SCANS - 1);
    localparam logic [6:0]        SEG_OFF    = {7{SEG_ACTIVE_LOW}};
    localparam logic              DP_OFF     = SEG_ACTIVE_LOW;
    localparam logic [DIGITS-1:0] AN_OFF     = {DIGITS{AN_ACTIVE_LOW}};

    typedef enum logic {
        PH_VISIBLE = 1'b0,
        PH_HIDDEN  = 1'b1
    } phase_t;

    logic [PW-1:0]            pre_cnt;
    logic [IW-1:0]            idx;
    logic [DIGITS-1:0][3:0]   shadow_bcd;
    logic [DIGITS-1:0]        shadow_dp;
    logic [DIGITS-1:0][3:0]   disp_bcd;
    logic [DIGITS-1:0]        disp_dp;
    phase_t                   phase_q;
    phase_t                   phase_d;
    logic [BW-1:0]            blink_cnt_q;
    logic [BW-1:0]            blink_cnt_d;

    logic                     slot_wrap_c;
    logic                     scan_wrap_c;
    logic [DIGITS-1:0]        lz_mask_c;
    logic                     zero_run_c;
    logic [3:0]               cur_code_c;
    logic                     cur_dp_c;
    logic                     cur_lz_c;
    logic [6:0]               lit_c;
    logic                     an_on_c;
    logic [DIGITS-1:0]        onehot_c;
    logic [6:0]               seg_c;
    logic                     dp_c;
    logic [DIGITS-1:0]        an_c;

    // BCD to segments, active-high sense, bit 6 = a ... bit 0 = g
    function automatic logic [6:0] decode_seg(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'd0:    s = 7'b1111110;
            4'd1:    s = 7'b0110000;
            4'd2:    s = 7'b1101101;
            4'd3:    s = 7'b1111001;
            4'd4:    s = 7'b0110011;
            4'd5:    s = 7'b1011011;
            4'd6:    s = 7'b1011111;
            4'd7:    s = 7'b1110000;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1111011;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    assign slot_wrap_c = (pre_cnt == PRE_LAST);
    assign scan_wrap_c = slot_wrap_c && (idx == IDX_LAST);

    // Slot prescaler and digit index
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt <= '0;
            idx     <= '0;
        end else begin
            pre_cnt <= slot_wrap_c ? '0 : pre_cnt + PW'(1);
            if (slot_wrap_c) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
            end
        end
    end

    // Shadow capture of the incoming BCD word and decimal points
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_bcd <= '0;
            shadow_dp  <= '0;
        end else if (load) begin
            shadow_bcd <= bcd_in;
            shadow_dp  <= dp_in;
        end
    end

    // Display copy refreshed only at slot boundaries so a load never changes a digit mid-slot
    always_ff @(posedge clk) begin
        if (rst) begin
            disp_bcd <= '0;
            disp_dp  <= '0;
        end else if (slot_wrap_c) begin
            disp_bcd <= shadow_bcd;
            disp_dp  <= shadow_dp;
        end
    end

    // Blink phase state register
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q     <= PH_VISIBLE;
            blink_cnt_q <= '0;
        end else begin
            phase_q     <= phase_d;
            blink_cnt_q <= blink_cnt_d;
        end
    end

    // Blink next state: count full scans, toggle phase every BLINK_SCANS of them
    always_comb begin
        phase_d     = phase_q;
        blink_cnt_d = blink_cnt_q;
        if (scan_wrap_c) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                phase_d     = (phase_q == PH_VISIBLE) ? PH_HIDDEN : PH_VISIBLE;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
            end
        end
    end

    // Leading-zero mask: a digit is blankable if it and all higher digits are zero
    always_comb begin
        lz_mask_c  = '0;
        zero_run_c = 1'b1;
        for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
            zero_run_c   = zero_run_c & (disp_bcd[k] == 4'd0);
            lz_mask_c[k] = zero_run_c & (k != 0);
        end
    end

    // Current digit selection
    always_comb begin
        cur_code_c = '0;
        cur_dp_c   = 1'b0;
        cur_lz_c   = 1'b0;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (idx == IW'(k)) begin
                cur_code_c = disp_bcd[k];
                cur_dp_c   = disp_dp[k];
                cur_lz_c   = blank_lz & lz_mask_c[k];
            end
        end
    end

    // Next output values; a blanked digit keeps its enable only to show its decimal point
    always_comb begin
        lit_c    = cur_lz_c ? 7'b0000000 : decode_seg(cur_code_c);
        onehot_c = DIGITS'(1) << idx;
        an_on_c  = !(cur_lz_c && !cur_dp_c) && !(blink_en && (phase_q == PH_HIDDEN));
        seg_c    = lit_c ^ SEG_OFF;
        dp_c     = cur_dp_c ^ DP_OFF;
        an_c     = an_on_c ? (onehot_c ^ AN_OFF) : AN_OFF;
    end

    // Registered board outputs and slot pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            seg       <= SEG_OFF;
            dp        <= DP_OFF;
            an        <= AN_OFF;
            slot_tick <= 1'b0;
        end else begin
            seg       <= seg_c;
            dp        <= dp_c;
            an        <= an_c;
            slot_tick <= slot_wrap_c;
        end
    end

endmodule

// File: doc/bcd_scan_display.md
Name: bcd_scan_display

Overview:
Multiplexed multi-digit 7-segment driver for lab boards with a shared segment bus.
- Captures a packed BCD word, decodes one digit per scan slot and drives the common digit-enable (anode) lines in rotation.
- Adds leading-zero blanking, per-digit decimal points and a whole-display blink mode.
- Sits between a BCD counter or datapath and the board display pins.

Parameters:
DIGITS, 4, number of digits scanned (1..8); digit 0 is the least significant.
PRESCALE, 50000, clock cycles per digit slot (>=2).
BLINK_SCANS, 64, full scan rotations per blink half-period (>=1).
SEG_ACTIVE_LOW, 1, 1 = segment lit when its output is 0.
AN_ACTIVE_LOW, 1, 1 = digit enabled when its output is 0.

Ports:
clk  in  1  system clock
rst  in  1  reset
bcd_in  in  4*DIGITS  packed BCD; digit k occupies bits [4k+3:4k]
dp_in  in  DIGITS  decimal-point request per digit
load  in  1  capture bcd_in/dp_in into shadow registers
blank_lz  in  1  enable leading-zero blanking
blink_en  in  1  enable display blink
seg  out  7  segments, bit 6 = a ... bit 0 = g
dp  out  1  decimal-point segment
an  out  DIGITS  digit enables, one-hot when active
slot_tick  out  1  one-cycle pulse when the digit index advances

Behaviour:
- Reset is synchronous and active-high on one clock, clk. rst is sampled only on the rising edge of clk and has priority over all other inputs.
- Reset state:
  - Prescaler = 0, digit index = 0, blink counter = 0, blink phase = visible.
  - Shadow BCD = 0, shadow dp = 0.
  - All an inactive, all seg/dp unlit (polarity per parameters), slot_tick = 0.
- Capture:
  - When load=1 at a clock edge, the shadow registers take bcd_in/dp_in on that edge.
  - The new value is displayed from the next slot boundary; the current slot keeps its old digit, so no mid-slot glitch.
  - Loading with no change is harmless.
- Prescaler:
  - Counts 0..PRESCALE-1, then wraps to 0.
  - On the wrap edge, slot_tick pulses for 1 cycle and the digit index advances.
  - After DIGITS-1 the index wraps to 0.
  - First slot_tick occurs PRESCALE cycles after reset release.
- Output latency:
  - seg, dp and an are registered from the current index and shadow data.
  - They change 1 cycle after the index changes, so they update together with no skew between the segment and digit-enable outputs.
- Decode (lit segments, active-high sense):
  - 0 = abcdef, 1 = bc, 2 = abdeg, 3 = abcdg, 4 = bcfg
  - 5 = acdfg, 6 = acdefg, 7 = abc, 8 = abcdefg, 9 = abcdfg
  - Codes 10..15: all unlit.
  - Output polarity is applied after decode.
- Leading-zero blanking:
  - When blank_lz=1, a digit is blanked (seg unlit, an inactive) if it and every higher digit are 0.
  - Digit 0 is never blanked, so a value of 0 shows a single "0".
  - dp is still shown on a blanked digit if its dp bit is set; in that case an stays active and seg is unlit.
- Blink:
  - The blink counter increments on each index wrap DIGITS-1 -> 0.
  - At BLINK_SCANS it clears and the blink phase toggles.
  - While blink_en=1 and the phase is hidden, all an are inactive.
  - The counters run regardless of blink_en. Deasserting blink_en restores the display on the next registered output update.
- DIGITS=1: the index stays at 0 and an is constantly active. slot_tick and the blink counting still operate.
- Reset mid-slot returns everything to the reset state on that edge. The shadow data is lost.

Test Plan:
- PRESCALE=4, DIGITS=4, load 0x1234 -> slot_tick every 4 cycles; an (active-low) cycles 1110, 1101, 1011, 0111; seg shows 4, 3, 2, 1 = 1001100, 0000110, 0010010, 1001111.
- Decode sweep: load each code 0..15 in digit 0, DIGITS=1 -> seg matches the table; 10..15 give 1111111 (active-low).
- blank_lz=1, load 0x0070 -> digits 3 and 2 have an inactive; digit 1 shows 7 (0001111); digit 0 shows 0 (0000001). Load 0x0000 -> only digit 0 active.
- dp_in=4'b0100 with 0x0005 and blank_lz=1 -> digit 2 has an active, seg 1111111, dp=0; the other digits have dp=1.
- load asserted mid-slot on digit 1 -> digit 1 keeps its old value until the next slot_tick. rst asserted mid-slot -> next cycle all an=1111, seg=1111111, index 0.
- BLINK_SCANS=2, blink_en=1 -> an stays all inactive for 2 full scans (32 cycles), then normal for 32 cycles. Deassert blink_en -> normal display within 1 cycle.
